// File: rtl/block_mem_responder.sv
// Block-transfer main-memory model: four-phase cs/ack handshake with a fixed access latency,
// whole-block reads/writes, and a single-word backdoor port for preload and inspection.

package block_mem_pkg;
  localparam int unsigned AddrWidth = 12;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BlockSize = 8;

  typedef struct packed {
    logic [AddrWidth-1:0]                addr;
    logic                                cs;
    logic                                rw;
    logic [BlockSize-1:0][DataWidth-1:0] data;
  } memory_request_t;

  typedef struct packed {
    logic                                ack;
    logic [BlockSize-1:0][DataWidth-1:0] data;
  } memory_response_t;
endpackage

module block_mem_responder #(
  parameter int unsigned ADDR_WIDTH = block_mem_pkg::AddrWidth,
  parameter int unsigned DATA_WIDTH = block_mem_pkg::DataWidth,
  parameter int unsigned BLOCK_SIZE = block_mem_pkg::BlockSize,
  parameter int unsigned MEM_WORDS  = 2 ** ADDR_WIDTH,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  block_mem_pkg::memory_request_t  mem_req,
  output block_mem_pkg::memory_response_t mem_resp,
  input  logic                            bd_we,
  input  logic [ADDR_WIDTH-1:0]           bd_addr,
  input  logic [DATA_WIDTH-1:0]           bd_wdata,
  output logic [DATA_WIDTH-1:0]           bd_rdata,
  output logic [15:0]                     rd_count,
  output logic [15:0]                     wr_count
);

  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int unsigned BLK_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;
  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [BLK_WIDTH-1:0]  blk_q, blk_d;
  logic                  rw_q, rw_d;
  block_t                wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  block_t                rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] bd_rdata_q, bd_rdata_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic                  blk_we;

  // Blocks are aligned, so the offset bits of the request address carry no information.
  logic unused_offset;
  assign unused_offset = ^mem_req.addr[OFFSET_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    ack_d      = ack_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    blk_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_req.cs) begin
          blk_d   = mem_req.addr[ADDR_WIDTH-1:OFFSET_WIDTH];
          rw_d    = mem_req.rw;
          wdata_d = mem_req.data;
          cnt_d   = 8'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!mem_req.cs) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          if (rw_q) begin
            blk_we = 1'b1;
            if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
          end else begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
              rdata_d[i] = mem[{blk_q, OFFSET_WIDTH'(i)}];
            end
            if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
          end
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAck: begin
        if (!mem_req.cs) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bd_rdata_d = mem[bd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      blk_q      <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      bd_rdata_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      bd_rdata_q <= bd_rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Block write is issued after the backdoor write so it wins on a same-word collision.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (blk_we && !rst) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        mem[{blk_q, OFFSET_WIDTH'(i)}] <= wdata_q[i];
      end
    end
  end

  assign mem_resp.ack  = ack_q;
  assign mem_resp.data = rdata_q;
  assign bd_rdata      = bd_rdata_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule
